first_system_seq_ctrl: RTL
==========================

// Module: first_system_seq_ctrl
// PURPOSE
//   Self-test sequencer for the 2-input/2-output first_system datapath.
//   - On start, drives dut_in1/dut_in2 through all four input codes 00,01,10,11.
//   - Holds each code for a programmable settle time, then samples dut_out1/dut_out2.
//   - Compares each sample against a parameterised truth table and reports pass/fail and an error count.
//   - Sits between a top-level control/status interface and the first_system instance.
// PARAMETERS
//   HOLD_CYCLES  4             settle cycles per input code before sampling; >=1 (0 is an elaboration error)
//   EXP_TABLE    8'b10010100   expected {out1,out2} per code; bits [2k+1:2k] belong to code k (default = half adder)
// PORTS
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   start     in   1  begin a test run; sampled only in IDLE
//   busy      out  1  high while a run is in progress (DRIVE/SAMPLE states)
//   done      out  1  one-cycle pulse at end of run
//   pass      out  1  1 = run finished with err_cnt==0; held until next accepted start
//   err_cnt   out  3  number of mismatching codes in last run (0..4)
//   dut_in1   out  1  drive to first_system in1 (MSB of code)
//   dut_in2   out  1  drive to first_system in2 (LSB of code)
//   dut_out1  in   1  first_system out1
//   dut_out2  in   1  first_system out2
//   resp_vec  out  8  captured responses; present only with FIRST_SYS_CTRL_CAPTURE_EN
// BEHAVIOUR
//   - Reset, asynchronous: state=IDLE, vec=0, hold_cnt=0.
//     - All outputs 0: dut_in1, dut_in2, busy, done, pass, err_cnt, resp_vec.
//   - All outputs are registered. Internal regs: vec[1:0]; hold_cnt sized for HOLD_CYCLES-1.
//   - FSM states: IDLE, DRIVE, SAMPLE, DONE.
//   - IDLE: dut_in={0,0}. On start=1:
//     - go to DRIVE; vec=0, hold_cnt=0, err_cnt=0, pass=0, busy=1.
//   - DRIVE: {dut_in1,dut_in2}=vec; hold_cnt increments each cycle.
//     - When hold_cnt==HOLD_CYCLES-1, go to SAMPLE.
//   - SAMPLE (1 cycle): compare {dut_out1,dut_out2} against EXP_TABLE[2*vec +: 2]; on mismatch err_cnt+=1.
//     - If vec==3: go to DONE.
//     - Else: vec+=1, hold_cnt=0, go to DRIVE.
//   - DONE (1 cycle): done=1, busy=0, pass=(err_cnt==0) using the err_cnt value that includes the code-3 compare.
//     - dut_in stays 11 this cycle. Next state IDLE; done returns to 0.
//   - Timing, start accepted at cycle 0:
//     - code k is driven from cycle 1+k*(HOLD_CYCLES+1), sampled HOLD_CYCLES cycles later.
//     - done pulses at cycle 1+4*(HOLD_CYCLES+1).
//   - Inputs dut_out* are treated as combinational responses to dut_in; no synchroniser.
//   - start is ignored in DRIVE/SAMPLE/DONE. A start held high restarts immediately after IDLE is re-entered.
//   - err_cnt never exceeds 4, so no wrap and no saturation logic.
//   - Reset mid-run aborts immediately: no done pulse, all outputs return to reset values.
// CONFIGURATION
//   - FIRST_SYS_CTRL_CAPTURE_EN defined:
//     - resp_vec[7:0] exists; cleared on accepted start.
//     - In SAMPLE, resp_vec[2*vec +: 2] = {dut_out1,dut_out2}.
//     - Holds after DONE until the next start or reset.
//   - Not defined: resp_vec port and capture registers are absent; all other behaviour is identical.
// TESTING
//   1. rst_n=0 at any time -> all outputs 0 within the same cycle; after release, IDLE with dut_in=00 and busy=0.
//   2. Golden half-adder model, HOLD_CYCLES=4, start pulse at cycle 0:
//      - dut_in = 00/01/10/11 at cycles 1/6/11/16.
//      - done pulses at cycle 21 with pass=1, err_cnt=0, resp_vec=8'h94.
//   3. Faulty model with out2 stuck at 0, HOLD_CYCLES=4 -> done at cycle 21, err_cnt=2, pass=0, resp_vec=8'h80.
//   4. Extra start pulses at cycles 3 and 12 during a run -> sequence and done timing identical to test 2.
//      start held high continuously -> second run begins at cycle 22 (IDLE) with dut_in=00 from cycle 23.
//   5. rst_n pulsed low at cycle 8 of a run -> no done pulse, err_cnt=0.
//      A new start afterwards completes a full clean run with pass=1.
//   6. HOLD_CYCLES=1, golden model -> dut_in changes at cycles 1/3/5/7; done at cycle 9, pass=1.

Source files
------------

// File: rtl/first_system_seq_ctrl_if.sv
// Control/status and datapath-side signals of the first_system self-test sequencer.
// FIRST_SYS_CTRL_CAPTURE_EN adds the captured response vector resp_vec.
interface first_system_seq_ctrl_if;
   logic       start;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_cnt;
   logic       dut_in1;
   logic       dut_in2;
   logic       dut_out1;
   logic       dut_out2;
`ifdef FIRST_SYS_CTRL_CAPTURE_EN
   logic [7:0] resp_vec;

   modport master (output start, dut_out1, dut_out2,
                   input  busy, done, pass, err_cnt, dut_in1, dut_in2, resp_vec);
   modport slave  (input  start, dut_out1, dut_out2,
                   output busy, done, pass, err_cnt, dut_in1, dut_in2, resp_vec);
`else
   modport master (output start, dut_out1, dut_out2,
                   input  busy, done, pass, err_cnt, dut_in1, dut_in2);
   modport slave  (input  start, dut_out1, dut_out2,
                   output busy, done, pass, err_cnt, dut_in1, dut_in2);
`endif
endinterface

// File: rtl/first_system_seq_ctrl.sv
// Self-test sequencer: walks codes 00..11 into first_system, checks responses against EXP_TABLE.
// Optional FIRST_SYS_CTRL_CAPTURE_EN records every sampled response in resp_vec.
module first_system_seq_ctrl #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter logic [7:0]  EXP_TABLE   = 8'b10010100
) (
   input logic                    clk,
   input logic                    rst_n,
   first_system_seq_ctrl_if.slave bus
);

   localparam int unsigned   HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DRIVE  = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   if (HOLD_CYCLES < 1) begin : g_hold_chk
      $error("HOLD_CYCLES must be at least 1");
   end

   logic [1:0]    state_q, state_d;
   logic [1:0]    vec_q, vec_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [2:0]    err_q, err_d;
   logic [1:0]    din_q, din_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic [1:0]    resp_s;
   logic          mismatch_s;
`ifdef FIRST_SYS_CTRL_CAPTURE_EN
   logic [7:0]    resp_q, resp_d;
`endif

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      state_d    = state_q;
      vec_d      = vec_q;
      hold_d     = hold_q;
      err_d      = err_q;
      din_d      = din_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pass_d     = pass_q;
      resp_s     = {bus.dut_out1, bus.dut_out2};
      mismatch_s = (resp_s != EXP_TABLE[{vec_q, 1'b0} +: 2]);
`ifdef FIRST_SYS_CTRL_CAPTURE_EN
      resp_d     = resp_q;
`endif
      case (state_q)
         S_IDLE: begin
            din_d = 2'b00;
            if (bus.start) begin
               state_d = S_DRIVE;
               vec_d   = 2'd0;
               hold_d  = '0;
               err_d   = 3'd0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
`ifdef FIRST_SYS_CTRL_CAPTURE_EN
               resp_d  = 8'h00;
`endif
            end
         end
         S_DRIVE: begin
            if (hold_q == HOLD_LAST) begin
               state_d = S_SAMPLE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         S_SAMPLE: begin
            err_d = err_q + {2'b00, mismatch_s};
`ifdef FIRST_SYS_CTRL_CAPTURE_EN
            resp_d[{vec_q, 1'b0} +: 2] = resp_s;
`endif
            if (vec_q == 2'd3) begin
               // pass must see the count that already includes the code-3 compare
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == 3'd0);
            end else begin
               state_d = S_DRIVE;
               vec_d   = vec_q + 2'd1;
               hold_d  = '0;
               din_d   = vec_d;
            end
         end
         default: begin
            state_d = S_IDLE;
            din_d   = 2'b00;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         vec_q   <= 2'd0;
         hold_q  <= '0;
         err_q   <= 3'd0;
         din_q   <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
`ifdef FIRST_SYS_CTRL_CAPTURE_EN
         resp_q  <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
`ifdef FIRST_SYS_CTRL_CAPTURE_EN
         resp_q  <= resp_d;
`endif
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.pass    = pass_q;
   assign bus.err_cnt = err_q;
   assign bus.dut_in1 = din_q[1];
   assign bus.dut_in2 = din_q[0];
`ifdef FIRST_SYS_CTRL_CAPTURE_EN
   assign bus.resp_vec = resp_q;
`endif

endmodule
